// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx_arbiter slice.
// Contents: the arbiter state encoding, the frame header magic nibble, the
// record geometry, and a helper that builds the frame header byte.
package uart_tx_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_STATE_IDLE = 1'b0,
        ARB_STATE_SEND = 1'b1
    } arb_state_e;

    localparam logic [3:0] ARB_HDR_MAGIC = 4'hA;
    localparam int         ARB_REC_BYTES = 3;
    localparam int         ARB_REC_W     = 8 * ARB_REC_BYTES;

    // Header byte: magic nibble in the top half so host software can
    // resynchronise on it, source index in the bottom half.
    function automatic logic [7:0] arb_hdr_byte(input logic [3:0] idx);
        return {ARB_HDR_MAGIC, idx};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req   - per-source request vector
//   last  - index of the previously granted source
//   win   - index of the first requesting source after 'last' (mod NREQ)
//   valid - high when at least one request is set
module uart_tx_arbiter_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [3:0]      last,
    output logic [3:0]      win,
    output logic            valid
);

    // Candidate index for scan step 'step', i.e. (last + step) mod NREQ.
    function automatic logic [3:0] wrap_idx(input logic [3:0] base, input int step);
        int s;
        s = (int'(base) + step) % NREQ;
        return s[3:0];
    endfunction

    logic hit_s;

    // Scan last+1, last+2, ... and keep the first set request found.
    always_comb begin
        win   = 4'd0;
        valid = 1'b0;
        hit_s = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                hit_s = !valid && req[k] && (wrap_idx(last, i) == 4'(k));
                win   = hit_s ? 4'(k) : win;
                valid = valid | hit_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between NREQ record sources.
// Grants sources round-robin per record and sends each record as a 4-byte
// frame: header {A, index}, flag, adr, dat.
// Ports:
//   clk_i     - system clock, rising edge
//   rst_i     - asynchronous active-low reset
//   req_i     - per-source request (level, held until grant)
//   rec_i     - per-source record {flag, adr, dat}, 24 bits per source
//   gnt_o     - one-hot one-cycle grant pulse (record latched)
//   tx_data_o - byte to the transmitter, held between strobes
//   tx_en_o   - one-cycle send strobe
//   tx_rdy_i  - transmitter idle
//   busy_o    - high from grant until the last byte strobe of a frame
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*ARB_REC_W-1:0] rec_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [7:0]                tx_data_o,
    output logic                      tx_en_o,
    input  logic                      tx_rdy_i,
    output logic                      busy_o
);

    localparam logic [3:0] LAST_RST = 4'(NREQ - 1);

    arb_state_e             state_r, state_s;
    logic [1:0]             cnt_r, cnt_s;
    logic [ARB_REC_W-1:0]   rec_r, rec_s;
    logic [3:0]             idx_r, idx_s;
    logic [3:0]             last_r, last_s;
    logic [NREQ-1:0]        gnt_r, gnt_s;
    logic                   tx_en_r, tx_en_s;
    logic [7:0]             tx_data_r, tx_data_s;
    logic                   busy_r, busy_s;

    logic [3:0]             win_s;
    logic                   valid_s;
    logic [ARB_REC_W-1:0]   rec_sel_s;
    logic [7:0]             byte_s;

    uart_tx_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req_i),
        .last  (last_r),
        .win   (win_s),
        .valid (valid_s)
    );

    // Select the winning source's record slice.
    always_comb begin
        rec_sel_s = {ARB_REC_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            rec_sel_s = (win_s == 4'(k)) ? rec_i[k*ARB_REC_W +: ARB_REC_W] : rec_sel_s;
        end
    end

    // Byte to issue for the current counter position.
    always_comb begin
        case (cnt_r)
            2'd0:    byte_s = arb_hdr_byte(idx_r);
            2'd1:    byte_s = rec_r[23:16];
            2'd2:    byte_s = rec_r[15:8];
            2'd3:    byte_s = rec_r[7:0];
            default: byte_s = 8'h00;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rec_s     = rec_r;
        idx_s     = idx_r;
        last_s    = last_r;
        gnt_s     = {NREQ{1'b0}};
        tx_en_s   = 1'b0;
        tx_data_s = tx_data_r;
        busy_s    = busy_r;
        case (state_r)
            ARB_STATE_IDLE: begin
                if (valid_s) begin
                    for (int k = 0; k < NREQ; k++) begin
                        gnt_s[k] = (win_s == 4'(k));
                    end
                    rec_s   = rec_sel_s;
                    idx_s   = win_s;
                    last_s  = win_s;
                    cnt_s   = 2'd0;
                    busy_s  = 1'b1;
                    state_s = ARB_STATE_SEND;
                end else begin
                    state_s = ARB_STATE_IDLE;
                end
            end
            ARB_STATE_SEND: begin
                // tx_en_r gates the cycle after a strobe, before the
                // transmitter has had a chance to drop its ready flag.
                if (tx_rdy_i && !tx_en_r) begin
                    tx_en_s   = 1'b1;
                    tx_data_s = byte_s;
                    cnt_s     = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        busy_s  = 1'b0;
                        state_s = ARB_STATE_IDLE;
                    end else begin
                        state_s = ARB_STATE_SEND;
                    end
                end else begin
                    state_s = ARB_STATE_SEND;
                end
            end
            default: begin
                state_s = ARB_STATE_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ARB_STATE_IDLE;
            cnt_r     <= 2'd0;
            rec_r     <= {ARB_REC_W{1'b0}};
            idx_r     <= 4'd0;
            last_r    <= LAST_RST;
            gnt_r     <= {NREQ{1'b0}};
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rec_r     <= rec_s;
            idx_r     <= idx_s;
            last_r    <= last_s;
            gnt_r     <= gnt_s;
            tx_en_r   <= tx_en_s;
            tx_data_r <= tx_data_s;
            busy_r    <= busy_s;
        end
    end

    assign gnt_o     = gnt_r;
    assign tx_en_o   = tx_en_r;
    assign tx_data_o = tx_data_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ = 2) with a uart_tx model
// that stays busy for 10 cycles after each strobe.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic [NREQ-1:0]    req_i = '0;
    logic [NREQ*24-1:0] rec_i = '0;
    logic [NREQ-1:0]    gnt_o;
    logic [7:0]         tx_data_o;
    logic               tx_en_o;
    logic               tx_rdy_i;
    logic               busy_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]      seen_bytes[$];
    logic [NREQ-1:0] seen_gnts[$];

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .rec_i     (rec_i),
        .gnt_o     (gnt_o),
        .tx_data_o (tx_data_o),
        .tx_en_o   (tx_en_o),
        .tx_rdy_i  (tx_rdy_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Transmitter model: ready drops the cycle after a strobe, busy 10 cycles.
    int   utx_busy = 0;
    logic stall    = 1'b0;
    always @(posedge clk_i) begin
        if (tx_en_o) utx_busy <= 10;
        else if (utx_busy > 0) utx_busy <= utx_busy - 1;
    end
    assign tx_rdy_i = (utx_busy == 0) && !stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first set request scanning last+1, last+2, ... mod NREQ.
    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Reference model and per-cycle compare.
    initial begin : cmp
        logic [7:0]      exp_q[$];
        bit              m_idle;
        int              m_last;
        logic            m_prev_en;
        logic [7:0]      m_data;
        int              since_strobe;
        logic [NREQ-1:0] r_s;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ*24-1:0] rec_s;
        logic [23:0]     rec;
        logic            rdy_s, rst_s, exp_en;
        int              w;
        m_idle = 1; m_last = NREQ - 1; m_prev_en = 0; m_data = 8'h00; since_strobe = 100;
        forever begin
            @(posedge clk_i);
            r_s = req_i; rdy_s = tx_rdy_i; rec_s = rec_i; rst_s = rst_i;
            #1;
            if (!rst_i || !rst_s) begin
                exp_q.delete();
                m_idle = 1; m_last = NREQ - 1; m_prev_en = 0; m_data = 8'h00; since_strobe = 100;
            end else begin
                exp_gnt = '0;
                exp_en  = 1'b0;
                if (m_idle) begin
                    if (r_s != '0) begin
                        w = rr_winner(r_s, m_last);
                        exp_gnt[w] = 1'b1;
                        m_last = w;
                        rec = rec_s[24*w +: 24];
                        exp_q.push_back({4'hA, 4'(w)});
                        exp_q.push_back(rec[23:16]);
                        exp_q.push_back(rec[15:8]);
                        exp_q.push_back(rec[7:0]);
                        m_idle = 0;
                    end
                end else if (rdy_s && !m_prev_en && exp_q.size() > 0) begin
                    exp_en = 1'b1;
                    m_data = exp_q.pop_front();
                    if (exp_q.size() == 0) m_idle = 1;
                end
                check("gnt", 64'(gnt_o), 64'(exp_gnt));
                check("tx_en", 64'(tx_en_o), 64'(exp_en));
                check("tx_data", 64'(tx_data_o), 64'(m_data));
                check("busy", 64'(busy_o), 64'(!m_idle));
                since_strobe++;
                if (tx_en_o) begin
                    check("strobe_spacing", 64'(since_strobe >= 2), 64'd1);
                    since_strobe = 0;
                    seen_bytes.push_back(tx_data_o);
                end
                if (gnt_o != '0) seen_gnts.push_back(gnt_o);
                m_prev_en = exp_en;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0; req_i = '0; stall = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen_bytes.delete();
        seen_gnts.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (seen_bytes.size() < n && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        check(name, 64'(seen_bytes.size() >= n), 64'd1);
    endtask

    initial begin : stim
        int t;
        int n_en;
        int n_g1;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_en", 64'(tx_en_o), 64'd0);
        check("rst_data", 64'(tx_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);

        // Single source
        do_reset();
        req_i[0] = 1'b1; rec_i[23:0] = 24'h013C5A;
        @(negedge clk_i);
        check("single_gnt", 64'(gnt_o), 64'h1);
        check("single_busy", 64'(busy_o), 64'd1);
        req_i[0] = 1'b0;
        wait_bytes(4, 200, "single_timeout");
        check("single_b0", 64'(seen_bytes[0]), 64'hA0);
        check("single_b1", 64'(seen_bytes[1]), 64'h01);
        check("single_b2", 64'(seen_bytes[2]), 64'h3C);
        check("single_b3", 64'(seen_bytes[3]), 64'h5A);
        check("single_busy_end", 64'(busy_o), 64'd0);

        // Contention
        do_reset();
        rec_i = {24'h222222, 24'h111111};
        req_i = 2'b11;
        t = 0;
        while (seen_bytes.size() < 16 && t < 600) begin
            @(negedge clk_i);
            for (int k = 0; k < NREQ; k++) begin
                if (gnt_o[k]) rec_i[24*k +: 24] = rec_i[24*k +: 24] + 24'h010101;
            end
            t++;
        end
        check("cont_timeout", 64'(seen_bytes.size() >= 16), 64'd1);
        check("cont_h0", 64'(seen_bytes[0]), 64'hA0);
        check("cont_h1", 64'(seen_bytes[4]), 64'hA1);
        check("cont_h2", 64'(seen_bytes[8]), 64'hA0);
        check("cont_h3", 64'(seen_bytes[12]), 64'hA1);
        check("cont_g0", 64'(seen_gnts[0]), 64'h1);
        check("cont_g1", 64'(seen_gnts[1]), 64'h2);
        check("cont_g2", 64'(seen_gnts[2]), 64'h1);
        check("cont_g3", 64'(seen_gnts[3]), 64'h2);

        // Slow transmitter
        do_reset();
        req_i[0] = 1'b1; rec_i[23:0] = 24'hC0FFEE;
        @(negedge clk_i);
        req_i[0] = 1'b0;
        wait_bytes(2, 200, "stall_timeout_a");
        stall = 1'b1;
        n_en = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (tx_en_o) n_en++;
        end
        check("stall_no_en", 64'(n_en), 64'd0);
        stall = 1'b0;
        wait_bytes(4, 200, "stall_timeout_b");
        repeat (30) @(negedge clk_i);
        check("stall_count", 64'(seen_bytes.size()), 64'd4);
        check("stall_b0", 64'(seen_bytes[0]), 64'hA0);
        check("stall_b1", 64'(seen_bytes[1]), 64'hC0);
        check("stall_b2", 64'(seen_bytes[2]), 64'hFF);
        check("stall_b3", 64'(seen_bytes[3]), 64'hEE);

        // Withdrawn request
        do_reset();
        req_i[0] = 1'b1; rec_i[23:0] = 24'h0A0B0C;
        @(negedge clk_i);
        req_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        req_i[1] = 1'b1; rec_i[47:24] = 24'h999999;
        @(negedge clk_i);
        req_i[1] = 1'b0;
        wait_bytes(4, 200, "wd_timeout");
        repeat (20) @(negedge clk_i);
        n_g1 = 0;
        foreach (seen_gnts[i]) if (seen_gnts[i][1]) n_g1++;
        check("wd_no_gnt1", 64'(n_g1), 64'd0);
        check("wd_bytes", 64'(seen_bytes.size()), 64'd4);
        check("wd_hdr", 64'(seen_bytes[0]), 64'hA0);

        // Reset mid-frame
        do_reset();
        req_i[0] = 1'b1; rec_i[23:0] = 24'h123456;
        @(negedge clk_i);
        req_i[0] = 1'b0;
        wait_bytes(2, 200, "rmf_timeout");
        #2 rst_i = 1'b0;
        #1;
        check("rmf_gnt", 64'(gnt_o), 64'd0);
        check("rmf_en", 64'(tx_en_o), 64'd0);
        check("rmf_data", 64'(tx_data_o), 64'd0);
        check("rmf_busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen_bytes.delete();
        seen_gnts.delete();
        req_i[1] = 1'b1; rec_i[47:24] = 24'h777777;
        @(negedge clk_i);
        check("rmf_gnt1", 64'(gnt_o), 64'h2);
        req_i[1] = 1'b0;
        wait_bytes(4, 200, "rmf_timeout_b");
        check("rmf_hdr", 64'(seen_bytes[0]), 64'hA1);
        check("rmf_b3", 64'(seen_bytes[3]), 64'h77);

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            @(negedge clk_i);
            for (int k = 0; k < NREQ; k++) begin
                if (gnt_o[k]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req_i[k] = 1'b1;
                        rec_i[24*k +: 24] = 24'($urandom);
                    end else begin
                        req_i[k] = 1'b0;
                    end
                end else if (!req_i[k]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req_i[k] = 1'b1;
                        rec_i[24*k +: 24] = 24'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_i[k] = 1'b0;
                end
            end
            stall = ($urandom_range(0, 9) < 2);
        end
        req_i = '0;
        stall = 1'b0;
        repeat (100) @(negedge clk_i);
        check("rand_activity", 64'(seen_gnts.size() > 10), 64'd1);
        check("rand_drained", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
